booth_mult_seq: RTL and testbench
=================================

// Module: booth_mult_seq
// PURPOSE
//   Parametrised sequential Booth multiplier: WIDTH x WIDTH -> 2*WIDTH product split into hi/lo.
//   Handles signed (mult) and unsigned (multu) operands per operation; start/busy/done handshake.
//   Sits beside the ALU in the datapath; the control FSM waits on done, then writes HI/LO.
// PARAMETERS
//   WIDTH   32   operand width in bits; must be even and >= 4
// PORTS
//   clk        in   1        rising-edge clock
//   Reset      in   1        asynchronous, active-high reset
//   a          in   WIDTH    multiplicand, sampled only on accepted start
//   b          in   WIDTH    multiplier, sampled only on accepted start
//   is_signed  in   1        1 = two's-complement operands, 0 = unsigned; sampled with start
//   start      in   1        request; accepted when the FSM is in IDLE
//   busy       out  1        high while an operation is in RUN
//   done       out  1        single-cycle pulse; hi/lo valid from this cycle
//   hi         out  WIDTH    product[2*WIDTH-1:WIDTH]
//   lo         out  WIDTH    product[WIDTH-1:0]
// BEHAVIOUR
//   Reset (async, any state): state=IDLE, busy=0, done=0, hi=0, lo=0, counter=0, datapath cleared.
//   States: IDLE -> RUN on start; RUN -> IDLE after ITER iterations (done=1 on that edge).
//   Operand prep at the start edge t0: a, b extended to WIDTH+2 bits (sign-ext if is_signed,
//     zero-ext otherwise); multiplicand and its negation latched; accumulator = {0, b_ext, 0}.
//   Radix-2 iteration: inspect pair {P[1],P[0]}: 01 add +M, 10 add -M, 00/11 none;
//     then arithmetic shift right by 1 (sign bit replicated). ITER = WIDTH+1.
//   Result: lower 2*WIDTH bits of the extended product; hi/lo updated only at completion.
//   Timing: start sampled high at edge t0 -> busy=1 after t0; iterations on edges t0+1..t0+ITER;
//     hi/lo written, done=1, busy=0 after edge t0+ITER; done drops after edge t0+ITER+1.
//   Latency (start edge to done visible) = ITER cycles (33 for WIDTH=32, radix-2).
//   start while busy=1: ignored, no effect on operands, counter or result.
//   start high in the done cycle: accepted (FSM already in IDLE); new op begins, old hi/lo held.
//   start held high continuously: back-to-back ops, one every ITER+1 cycles.
//   a, b, is_signed changing during RUN: ignored (latched copies used).
//   hi/lo hold the last result until the next completion; never cleared by start.
//   Reset asserted mid-RUN: op aborted, no done pulse, outputs return to reset values.
//   Corner: signed -2^(W-1) * -2^(W-1) = 2^(2W-2) exact (no overflow; extension covers it).
// CONFIGURATION
//   BOOTH_RADIX4_EN defined: radix-4 recoding; triple {P[2],P[1],P[0]} selects 0, +-M, +-2M,
//     arithmetic shift right by 2 per iteration; ITER = (WIDTH+2)/2 (17 for WIDTH=32).
//     Handshake, reset and boundary rules unchanged; only ITER differs.
//   Not defined: radix-2 datapath only, ITER = WIDTH+1; no 2M adder instantiated.
// TESTING
//   Reset during idle and mid-RUN (cycle 10) -> busy=0, done=0, hi=lo=0, no done pulse.
//   signed a=7, b=-3 -> after ITER cycles hi=0xFFFFFFFF, lo=0xFFFFFFEB, done one cycle.
//   unsigned a=0xFFFFFFFF, b=0xFFFFFFFF -> hi=0xFFFFFFFE, lo=0x00000001;
//     same operands signed -> hi=0x00000000, lo=0x00000001.
//   signed a=b=0x80000000 -> hi=0x40000000, lo=0x00000000.
//   start re-pulsed at cycle 5 of RUN with new operands -> ignored, first result returned;
//     start held high -> done pulses every ITER+1 cycles, hi/lo stable between pulses.
//   Random 10k signed/unsigned pairs, both macro settings, vs 64-bit reference model;
//     check done exactly ITER cycles after start.

Source files
------------

// File: rtl/booth_mult_seq.sv
// booth_mult_seq: sequential Booth multiplier, WIDTH x WIDTH -> {hi,lo}, signed/unsigned per op.
// Define BOOTH_RADIX4_EN for radix-4 recoding (WIDTH/2+1 iterations); default is radix-2 (WIDTH+1).
module booth_mult_seq #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             Reset,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             is_signed,
  input  logic             start,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);
  localparam int XW = WIDTH + 2;
  localparam int AW = XW + 2;
  localparam int PW = AW + XW + 1;
`ifdef BOOTH_RADIX4_EN
  localparam int ITER = XW / 2;
  localparam int SH   = 2;
  localparam int LSB  = 1;
`else
  localparam int ITER = WIDTH + 1;
  localparam int SH   = 1;
  localparam int LSB  = 2;
`endif
  localparam int CW = $clog2(ITER + 1);

  typedef enum logic {S_IDLE, S_RUN} state_t;

  state_t           r_state;
  logic [CW-1:0]    r_cnt;
  logic [AW-1:0]    r_m;
  logic [AW-1:0]    r_m_neg;
  logic [PW-1:0]    r_p;
  logic [AW-1:0]    w_m_ext;
  logic [XW-1:0]    w_b_ext;
  logic [AW-1:0]    w_add;
  logic [AW-1:0]    w_sum;
  logic [PW-1:0]    w_p_sum;
  logic [PW-1:0]    w_p_next;
  logic [2*WIDTH-1:0] w_prod;

  assign w_m_ext = {{4{is_signed & a[WIDTH-1]}}, a};
  assign w_b_ext = {{2{is_signed & b[WIDTH-1]}}, b};

`ifdef BOOTH_RADIX4_EN
  // Radix-4 recoding of {P[2],P[1],P[0]} into 0, +-M, +-2M.
  always_comb begin
    w_add = (r_p[2:0] == 3'b001 || r_p[2:0] == 3'b010) ? r_m :
            (r_p[2:0] == 3'b011) ? {r_m[AW-2:0], 1'b0} :
            (r_p[2:0] == 3'b100) ? {r_m_neg[AW-2:0], 1'b0} :
            (r_p[2:0] == 3'b101 || r_p[2:0] == 3'b110) ? r_m_neg : '0;
  end
`else
  // Radix-2 recoding of {P[1],P[0]} into 0, +M or -M.
  always_comb begin
    w_add = (r_p[1:0] == 2'b01) ? r_m :
            (r_p[1:0] == 2'b10) ? r_m_neg : '0;
  end
`endif

  // Accumulator gets two guard bits above the extended operand so +-2M never overflows.
  assign w_sum    = r_p[PW-1:XW+1] + w_add;
  assign w_p_sum  = {w_sum, r_p[XW:0]};
  assign w_p_next = PW'($signed(w_p_sum) >>> SH);
  assign w_prod   = w_p_next[2*WIDTH+LSB-1:LSB];

  // Control FSM and datapath: latch operands on start, iterate ITER times, publish result with done.
  always_ff @(posedge clk or posedge Reset) begin
    if (Reset) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_m     <= '0;
      r_m_neg <= '0;
      r_p     <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
      hi      <= '0;
      lo      <= '0;
    end else begin
      done <= 1'b0;
      if (r_state == S_IDLE) begin
        if (start) begin
          r_state <= S_RUN;
          busy    <= 1'b1;
          r_cnt   <= '0;
          r_m     <= w_m_ext;
          r_m_neg <= -w_m_ext;
          r_p     <= {{AW{1'b0}}, w_b_ext, 1'b0};
        end
      end else begin
        r_p   <= w_p_next;
        r_cnt <= r_cnt + CW'(1);
        if (r_cnt == CW'(ITER - 1)) begin
          r_state  <= S_IDLE;
          busy     <= 1'b0;
          done     <= 1'b1;
          {hi, lo} <= w_prod;
        end
      end
    end
  end
endmodule

// File: tb/tb_booth_mult_seq.sv
// tb_booth_mult_seq: directed checks of booth_mult_seq (products, latency, handshake, reset).
module tb_booth_mult_seq;
  localparam int W = 32;
`ifdef BOOTH_RADIX4_EN
  localparam int ITER = (W + 2) / 2;
`else
  localparam int ITER = W + 1;
`endif

  logic         clk = 1'b0;
  logic         Reset = 1'b1;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         is_signed = 1'b0;
  logic         start = 1'b0;
  logic         busy;
  logic         done;
  logic [W-1:0] hi;
  logic [W-1:0] lo;

  int n_tests = 0;
  int n_fail  = 0;

  booth_mult_seq #(.WIDTH(W)) dut (
    .clk(clk), .Reset(Reset), .a(a), .b(b), .is_signed(is_signed), .start(start),
    .busy(busy), .done(done), .hi(hi), .lo(lo)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic run_op(input string tag, input logic [W-1:0] ia, input logic [W-1:0] ib,
                        input logic s, input logic [63:0] exp);
    int cyc = 0;
    @(negedge clk);
    a = ia; b = ib; is_signed = s; start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    check({tag, "_busy"}, 64'(busy), 64'd1);
    while (!done && cyc < ITER + 10) begin
      @(negedge clk);
      cyc++;
    end
    check({tag, "_lat"}, 64'(cyc), 64'(ITER));
    check({tag, "_prod"}, {hi, lo}, exp);
    @(negedge clk);
    check({tag, "_drop"}, 64'({busy, done}), 64'd0);
    check({tag, "_hold"}, {hi, lo}, exp);
  endtask

  initial begin
    int cyc;
    int dones;
    logic stable;
    repeat (2) @(negedge clk);
    check("rst_ctl", 64'({busy, done}), 64'd0);
    check("rst_res", {hi, lo}, 64'd0);
    Reset = 1'b0;

    run_op("s_7x-3",   32'd7,          32'hFFFF_FFFD, 1'b1, 64'hFFFF_FFFF_FFFF_FFEB);
    run_op("u_maxsq",  32'hFFFF_FFFF,  32'hFFFF_FFFF, 1'b0, 64'hFFFF_FFFE_0000_0001);
    run_op("s_m1sq",   32'hFFFF_FFFF,  32'hFFFF_FFFF, 1'b1, 64'h0000_0000_0000_0001);
    run_op("s_minsq",  32'h8000_0000,  32'h8000_0000, 1'b1, 64'h4000_0000_0000_0000);
    run_op("u_minsq",  32'h8000_0000,  32'h8000_0000, 1'b0, 64'h4000_0000_0000_0000);
    run_op("u_2p16sq", 32'h0001_0000,  32'h0001_0000, 1'b0, 64'h0000_0001_0000_0000);
    run_op("s_minx1",  32'h8000_0000,  32'd1,         1'b1, 64'hFFFF_FFFF_8000_0000);
    run_op("u_x0",     32'h1234_5678,  32'd0,         1'b0, 64'd0);
    run_op("s_maxxmin",32'h7FFF_FFFF,  32'h8000_0000, 1'b1, 64'hC000_0000_8000_0000);
    run_op("u_2x3",    32'd2,          32'd3,         1'b0, 64'd6);

    // start re-pulsed with new operands mid-run must be ignored
    @(negedge clk);
    a = 32'd7; b = 32'hFFFF_FFFD; is_signed = 1'b1; start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    cyc = 0;
    while (!done && cyc < ITER + 10) begin
      @(negedge clk);
      cyc++;
      start = (cyc == 5);
      if (cyc == 5) begin a = 32'd2; b = 32'd3; is_signed = 1'b0; end
      check("ign_old_res", {hi, lo}, done ? 64'hFFFF_FFFF_FFFF_FFEB : 64'd6);
    end
    check("ign_lat", 64'(cyc), 64'(ITER));
    check("ign_prod", {hi, lo}, 64'hFFFF_FFFF_FFFF_FFEB);
    @(negedge clk);
    check("ign_idle", 64'({busy, done}), 64'd0);

    // start held high: back-to-back ops, start accepted in the done cycle
    @(negedge clk);
    a = 32'd2; b = 32'd3; is_signed = 1'b0; start = 1'b1;
    @(posedge clk);
    cyc = 0;
    while (!done && cyc < ITER + 10) begin
      @(negedge clk);
      cyc++;
    end
    check("b2b_prod1", {hi, lo}, 64'd6);
    a = 32'd5; b = 32'hFFFF_FFFE; is_signed = 1'b1;
    cyc = 0;
    stable = 1'b1;
    @(negedge clk);
    cyc++;
    while (!done && cyc < 2 * ITER + 10) begin
      if ({hi, lo} !== 64'd6 || !busy) stable = 1'b0;
      @(negedge clk);
      cyc++;
    end
    start = 1'b0;
    check("b2b_stable", 64'(stable), 64'd1);
    check("b2b_period", 64'(cyc), 64'(ITER + 1));
    check("b2b_prod2", {hi, lo}, 64'hFFFF_FFFF_FFFF_FFF6);
    @(negedge clk);
    check("b2b_stop", 64'({busy, done}), 64'd0);

    // reset while idle clears the held result
    Reset = 1'b1;
    #1;
    check("rst_idle_res", {hi, lo}, 64'd0);
    @(negedge clk);
    Reset = 1'b0;
    run_op("s_pre", 32'd7, 32'hFFFF_FFFD, 1'b1, 64'hFFFF_FFFF_FFFF_FFEB);

    // reset mid-run: aborted, no done pulse, outputs cleared
    @(negedge clk);
    a = 32'd3; b = 32'd4; is_signed = 1'b0; start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    repeat (10) @(negedge clk);
    Reset = 1'b1;
    #1;
    check("rst_run_ctl", 64'({busy, done}), 64'd0);
    check("rst_run_res", {hi, lo}, 64'd0);
    @(negedge clk);
    Reset = 1'b0;
    dones = 0;
    for (int i = 0; i < ITER + 5; i++) begin
      @(negedge clk);
      if (done || busy) dones++;
    end
    check("rst_run_nodone", 64'(dones), 64'd0);
    check("rst_run_res2", {hi, lo}, 64'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
